// File: rtl/midi_tx.sv
// MIDI note-on/note-off encoder: serialises each request into status/note/velocity
// bytes over a valid/ready byte handshake. Define MIDI_RUNNING_STATUS_EN for running status.
module midi_tx #(
  parameter int MIDI_CHANNEL = 0,
  parameter int OFF_VELOCITY = 64,
  parameter int RS_TIMEOUT   = 1024
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       noteOnReq_i,
  input  logic       noteOffReq_i,
  input  logic [6:0] note_i,
  input  logic [6:0] velocity_i,
  output logic       reqReady_o,
  output logic [7:0] midiByte_o,
  output logic       midiByteValid_o,
  input  logic       midiByteReady_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic [6:0] note;
    logic [6:0] vel;
  } msg_t;

  localparam logic [3:0] CH    = 4'(MIDI_CHANNEL);
  localparam logic [6:0] OFF_V = 7'(OFF_VELOCITY);

  if (MIDI_CHANNEL < 0 || MIDI_CHANNEL > 15 || RS_TIMEOUT < 1) begin : g_param_check
    $error("midi_tx: MIDI_CHANNEL must be 0..15 and RS_TIMEOUT >= 1");
  end

  state_t     state;
  msg_t       msg;
  logic       ready_q;
  logic       req;
  logic       xfer;
  logic       rs_hit;
  logic [3:0] cmd_new;
  logic [6:0] vel_new;

  // Note-off wins when both requests arrive together.
  assign req     = noteOnReq_i | noteOffReq_i;
  assign cmd_new = noteOffReq_i ? 4'h8 : 4'h9;
  assign vel_new = noteOffReq_i ? OFF_V : velocity_i;
  assign xfer    = midiByteValid_o & midiByteReady_i;

  assign reqReady_o = ready_q;
  assign busy_o     = ~ready_q;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam int CW = $clog2(RS_TIMEOUT + 1);

  logic [7:0]    last_status;
  logic          rs_vld;
  logic [CW-1:0] idle_cnt;

  assign rs_hit = rs_vld && (last_status == {cmd_new, CH});

  // Cache is dropped on the cycle the idle count reaches RS_TIMEOUT.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      last_status <= 8'h00;
      rs_vld      <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      if (state == STATUS && xfer) begin
        last_status <= midiByte_o;
        rs_vld      <= 1'b1;
      end
      if (state == IDLE && !req) begin
        if (idle_cnt != CW'(RS_TIMEOUT)) begin
          idle_cnt <= idle_cnt + 1'b1;
          if (idle_cnt == CW'(RS_TIMEOUT - 1)) rs_vld <= 1'b0;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end
`else
  assign rs_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state           <= IDLE;
      msg             <= '0;
      ready_q         <= 1'b1;
      midiByte_o      <= 8'h00;
      midiByteValid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            msg             <= '{cmd: cmd_new, note: note_i, vel: vel_new};
            ready_q         <= 1'b0;
            midiByteValid_o <= 1'b1;
            if (rs_hit) begin
              state      <= NOTE;
              midiByte_o <= {1'b0, note_i};
            end else begin
              state      <= STATUS;
              midiByte_o <= {cmd_new, CH};
            end
          end
        end
        STATUS: begin
          if (xfer) begin
            state      <= NOTE;
            midiByte_o <= {1'b0, msg.note};
          end else begin
            midiByte_o <= {msg.cmd, CH};
          end
        end
        NOTE: begin
          if (xfer) begin
            state      <= VEL;
            midiByte_o <= {1'b0, msg.vel};
          end
        end
        VEL: begin
          if (xfer) begin
            state           <= IDLE;
            midiByte_o      <= 8'h00;
            midiByteValid_o <= 1'b0;
            ready_q         <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (channel 0 and 5) share stimulus and are
// checked every cycle against a byte-queue model, plus literal sequence pins.
module tb_midi_tx;
  localparam int TO = 8;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic clk = 0, nrst = 0, on = 0, off = 0, rdy = 1;
  logic [6:0] note = 0, vel = 0;
  logic rr0, bz0, v0, rr5, bz5, v5;
  logic [7:0] b0, b5;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  midi_tx #(.MIDI_CHANNEL(0), .OFF_VELOCITY(64), .RS_TIMEOUT(TO)) dut0 (
    .clk_i(clk), .nrst_i(nrst), .noteOnReq_i(on), .noteOffReq_i(off),
    .note_i(note), .velocity_i(vel), .reqReady_o(rr0), .midiByte_o(b0),
    .midiByteValid_o(v0), .midiByteReady_i(rdy), .busy_o(bz0));

  midi_tx #(.MIDI_CHANNEL(5), .OFF_VELOCITY(64), .RS_TIMEOUT(TO)) dut5 (
    .clk_i(clk), .nrst_i(nrst), .noteOnReq_i(on), .noteOffReq_i(off),
    .note_i(note), .velocity_i(vel), .reqReady_o(rr5), .midiByte_o(b5),
    .midiByteValid_o(v5), .midiByteReady_i(rdy), .busy_o(bz5));

  // Model: queue of bytes still to be sent for the current message; bit8 marks
  // the status byte so each instance ORs in its own channel.
  logic [8:0] q[$];
  logic [3:0] last_cmd;
  bit         rsv;
  int         idle;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q.delete();
      rsv      <= 1'b0;
      idle     <= 0;
      last_cmd <= 4'h0;
    end else if (q.size() != 0) begin
      idle <= 0;
      if (rdy) begin
        if (q[0][8]) begin
          last_cmd <= q[0][7:4];
          rsv      <= 1'b1;
        end
        void'(q.pop_front());
      end
    end else if (on || off) begin
      idle <= 0;
      if (!(RS && rsv && last_cmd == (off ? 4'h8 : 4'h9)))
        q.push_back({1'b1, (off ? 4'h8 : 4'h9), 4'h0});
      q.push_back({2'b00, note});
      q.push_back({2'b00, (off ? 7'd64 : vel)});
    end else if (idle < TO) begin
      idle <= idle + 1;
      if (idle + 1 == TO) rsv <= 1'b0;
    end
  end

  function automatic logic [7:0] exp_byte(logic [3:0] ch);
    if (q.size() == 0) return 8'h00;
    return q[0][8] ? {q[0][7:4], ch} : q[0][7:0];
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      chk("rdy0", 8'(rr0), 8'(q.size() == 0));
      chk("busy0", 8'(bz0), 8'(q.size() != 0));
      chk("vld0", 8'(v0), 8'(q.size() != 0));
      chk("byte0", b0, exp_byte(4'h0));
      chk("rdy5", 8'(rr5), 8'(q.size() == 0));
      chk("busy5", 8'(bz5), 8'(q.size() != 0));
      chk("vld5", 8'(v5), 8'(q.size() != 0));
      chk("byte5", b5, exp_byte(4'h5));
    end
  end

  logic [7:0] log0[$], log5[$];
  always @(posedge clk) begin
    if (nrst && v0 && rdy) log0.push_back(b0);
    if (nrst && v5 && rdy) log5.push_back(b5);
  end

  task automatic chk_seq(string nm, int which, int n, logic [47:0] e);
    logic [7:0] got;
    chk({nm, " len"}, 8'(which == 0 ? log0.size() : log5.size()), 8'(n));
    for (int i = 0; i < n; i++) begin
      if (which == 0) got = (i < log0.size()) ? log0[i] : 8'hxx;
      else            got = (i < log5.size()) ? log5[i] : 8'hxx;
      chk(nm, got, e[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic clr_logs();
    log0.delete();
    log5.delete();
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the request until the encoder takes it; returns 1ns after the accepting edge.
  task automatic send(bit o, bit f, logic [6:0] n, logic [6:0] v);
    on = o; off = f; note = n; vel = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rr0) begin
        @(posedge clk);
        #1;
        on = 0; off = 0;
        return;
      end
    end
    checks++; errs++;
    $display("FAIL send: got no acceptance want acceptance within 200 cycles");
    on = 0; off = 0;
  endtask

  task automatic do_reset();
    nrst = 0;
    cycles(2);
    nrst = 1;
    cycles(1);
    clr_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    cycles(2);
    chk("reset rdy", 8'(rr0), 8'h01);
    chk("reset busy", 8'(bz0), 8'h00);
    chk("reset vld", 8'(v0), 8'h00);
    chk("reset byte", b0, 8'h00);
    nrst = 1;
    cycles(1);

    // note-on 60/100, ready high: one byte per cycle, then idle
    send(1, 0, 7'd60, 7'd100);
    chk("t1 b1", b0, 8'h90); chk("t1 b1 ch5", b5, 8'h95);
    cycles(1); chk("t1 b2", b0, 8'h3C);
    cycles(1); chk("t1 b3", b0, 8'h64);
    cycles(1); chk("t1 rdy", 8'(rr0), 8'h01); chk("t1 vld", 8'(v0), 8'h00);
    chk_seq("t1 seq", 0, 3, 48'h90_3C_64);
    clr_logs();

    // note-off 0x45 carries the fixed off velocity
    send(0, 1, 7'h45, 7'h7F);
    cycles(5);
    chk_seq("t2 seq0", 0, 3, 48'h80_45_40);
    chk_seq("t2 seq5", 1, 3, 48'h85_45_40);
    clr_logs();

    // ready pattern 1,0,0,1,1 with stalls in NOTE
    send(1, 0, 7'h30, 7'h11);
    rdy = 1; cycles(1);
    rdy = 0; chk("t3 hold a", b0, 8'h30); cycles(1);
    chk("t3 hold b", b0, 8'h30); cycles(1);
    rdy = 1; cycles(1);
    cycles(1);
    cycles(3);
    chk_seq("t3 seq", 0, 3, 48'h90_30_11);
    clr_logs();

    // simultaneous on/off: only the note-off is sent
    send(1, 1, 7'd10, 7'd99);
    cycles(6);
    chk_seq("t4 seq", 0, 3, 48'h80_0A_40);
    clr_logs();

    // long stall, note 127, velocity 0 stays a note-on
    rdy = 0;
    send(1, 0, 7'd127, 7'd0);
    cycles(30);
    chk("t6 stall byte", b0, 8'h90);
    rdy = 1;
    cycles(5);
    chk_seq("t6 seq", 0, 3, 48'h90_7F_00);
    clr_logs();

    // reset right after the status transfer aborts the message
    send(1, 0, 7'd60, 7'd100);
    @(posedge clk);
    #2 nrst = 0;
    #1;
    chk("t5 vld async", 8'(v0), 8'h00);
    chk("t5 byte async", b0, 8'h00);
    chk("t5 rdy async", 8'(rr0), 8'h01);
    @(posedge clk);
    #1 nrst = 1;
    cycles(6);
    chk_seq("t5 seq", 0, 1, 48'h90);
    clr_logs();

    // back-to-back note-ons
    do_reset();
    send(1, 0, 7'd60, 7'd100);
    send(1, 0, 7'd62, 7'd90);
    cycles(6);
`ifdef MIDI_RUNNING_STATUS_EN
    chk_seq("rs b2b", 0, 5, 48'h90_3C_64_3E_5A);
    chk_seq("rs b2b ch5", 1, 5, 48'h95_3C_64_3E_5A);
    clr_logs();
    cycles(10);
    send(1, 0, 7'd64, 7'd80);
    cycles(5);
    chk_seq("rs timeout", 0, 3, 48'h90_40_50);
`else
    chk_seq("b2b", 0, 6, 48'h90_3C_64_90_3E_5A);
`endif
    clr_logs();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- MIDI message encoder, the transmit-side counterpart of the MIDI note parser.
- Accepts note-on/note-off requests from the synth/sequencer logic and serialises each into a 3-byte Channel Voice Message: status, note, velocity.
- Bytes are presented to the UART transmitter over a valid/ready byte handshake.
- Only 0x8n (note off) and 0x9n (note on) are generated.

Parameters:
- MIDI_CHANNEL, 0, channel nibble n placed in the status byte (0..15).
- OFF_VELOCITY, 64, velocity byte sent with every note-off (7-bit).
- RS_TIMEOUT, 1024, idle cycles before the running-status cache is invalidated (used only with MIDI_RUNNING_STATUS_EN).

Ports:
- clk_i  input  1  system clock.
- nrst_i  input  1  reset: asynchronous, active-low.
- noteOnReq_i  input  1  request a note-on; taken when reqReady_o=1.
- noteOffReq_i  input  1  request a note-off; taken when reqReady_o=1.
- note_i  input  7  note number, sampled at request acceptance.
- velocity_i  input  7  note-on velocity, sampled at acceptance; ignored for note-off.
- reqReady_o  output  1  encoder idle; a request is accepted this cycle.
- midiByte_o  output  8  byte to transmit.
- midiByteValid_o  output  1  midiByte_o is valid.
- midiByteReady_i  input  1  UART transmitter accepts the byte.
- busy_o  output  1  message in flight (the inverse of reqReady_o).

Behaviour:
- Reset values: reqReady_o=1, busy_o=0, midiByteValid_o=0, midiByte_o=0x00, FSM in IDLE, latched cmd/note/vel=0.
- Reset is fully asynchronous. Asserting it mid-message aborts the message immediately; no partial completion after release.
- FSM states are IDLE, STATUS, NOTE, VEL.
  - IDLE: reqReady_o=1. On a request at a rising edge:
    - latch cmd (0x9 on, 0x8 off), note_i and velocity_i (or OFF_VELOCITY for off);
    - go to STATUS.
  - STATUS: midiByteValid_o=1, midiByte_o={cmd,MIDI_CHANNEL[3:0]}. On transfer, go to NOTE.
  - NOTE: midiByte_o={1'b0,note}. On transfer, go to VEL.
  - VEL: midiByte_o={1'b0,vel}. On transfer, go to IDLE.
- A transfer occurs when midiByteValid_o && midiByteReady_i at the rising edge.
- Without a transfer, the state and midiByte_o hold stable. Valid never drops before the transfer.
- midiByte_o and midiByteValid_o are registered outputs. The first byte appears the cycle after acceptance.
- Minimum message time: 1 accept cycle + 3 transfer cycles. A new request is accepted in the cycle after the VEL transfer, not in the same cycle.
- Data bytes always have bit7=0. Inputs are 7-bit, so no masking beyond zero-extension is needed.
- Simultaneous noteOnReq_i and noteOffReq_i in IDLE: note-off wins and the note-on is dropped (no queueing).
- Requests while busy are ignored. Requesters must hold the request until reqReady_o=1.
- midiByteReady_i held low indefinitely: the FSM stalls in its current state, with no timeout.
- Note-on with velocity 0 is sent literally as 0x9n, not converted to note-off.
- midiByte_o returns to 0x00 in IDLE.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- With the macro:
  - A lastStatus register plus a valid flag cache the most recently sent status byte.
  - On acceptance, if the flag is set and the new status equals lastStatus, STATUS is skipped: NOTE is the first byte presented and the message is 2 bytes.
  - The flag is cleared on reset, and when an RS_TIMEOUT-cycle idle counter expires. The counter counts consecutive cycles in IDLE with no request and saturates.
  - The flag is set and lastStatus updated on every status-byte transfer.
- Without the macro:
  - No cache or counter logic exists; every message is 3 bytes.
  - RS_TIMEOUT is unused.

Test Plan:
- Reset, then noteOn note=60 vel=100 with ready always high → bytes 0x90,0x3C,0x64 on 3 consecutive cycles; reqReady_o high again on the next cycle.
- MIDI_CHANNEL=5, noteOff note=0x45 → 0x85,0x45,0x40.
- Ready toggled 1,0,0,1,1 during a note-on → each byte held stable while not accepted; exactly 3 transfers in order.
- Simultaneous on and off requests, note=10 → single message 0x80,0x0A,0x40; no 0x90 ever emitted.
- Reset asserted after the 0x90 transfer → valid drops asynchronously to 0; after release there are no bytes until a new request.
- With MIDI_RUNNING_STATUS_EN, RS_TIMEOUT=8:
  - noteOn 60/100 then noteOn 62/90 back-to-back → 0x90,0x3C,0x64,0x3E,0x5A.
  - After 8 idle cycles, noteOn 64/80 → 0x90,0x40,0x50.
